bcd_stopwatch_core: RTL and testbench

Parametrised N-digit BCD stopwatch core: the successor of the two-digit stopwatch. It adds a configurable digit count and tick rate, and a start/stop toggle. It also adds a lap (split) hold that freezes the display while counting continues, plus multiplexed common-anode 7-segment drive for any digit count. It sits directly behind the Pmod pin mapping in the top level. Buttons arrive raw from `ui_in`, and segment/digit-select lines go straight to `uo_out`/`uio_out`.

---
 rtl/stopwatch_pkg.sv | 48 ++++
 rtl/bcd_stopwatch_core_if.sv | 32 +++
 rtl/bcd_counter_n.sv | 54 +++++
 rtl/bcd_stopwatch_core.sv | 149 ++++++++++++++
 tb/tb_bcd_stopwatch_core.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the BCD stopwatch core:
//   sw_state_e   - control FSM state set (IDLE, RUNNING, STOPPED, LAP)
//   bcd_digit_t  - one BCD digit
//   SEG_*        - active-high 7-segment patterns, bit0 = a .. bit6 = g
//   bcd_to_seg() - digit to active-high pattern; 10..15 decode to blank
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_stopwatch_core_if.sv
// ---------------------------------------------------------------------------
// stopwatch_if
// Button inputs and display/status outputs of the stopwatch core.
//   btn_clear, btn_startstop, btn_lap : raw asynchronous buttons
//   seg[6:0] (active-low, bit0 = a), dp (active-low)
//   dig_sel[NUM_DIGITS-1:0]           : active-low one-hot digit enable
//   running, lap_active, wrap         : status
// Modport slave is the core side, master is the board/pin side.
// ---------------------------------------------------------------------------
interface stopwatch_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  btn_clear;
  logic                  btn_startstop;
  logic                  btn_lap;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  running;
  logic                  lap_active;
  logic                  wrap;

  modport slave (
    input  btn_clear, btn_startstop, btn_lap,
    output seg, dp, dig_sel, running, lap_active, wrap
  );

  modport master (
    output btn_clear, btn_startstop, btn_lap,
    input  seg, dp, dig_sel, running, lap_active, wrap
  );
endinterface

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
// NUM_DIGITS-digit BCD up-counter with per-digit ripple carry.
//   CLK, RST : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over inc)
//   inc      : advance the count by one
//   count    : packed BCD, digit 0 in bits [3:0]
//   wrap     : high for the single cycle after an all-9s -> all-0s rollover
// ---------------------------------------------------------------------------
module bcd_counter_n #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr,
  input  logic                    inc,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap
);
  import stopwatch_pkg::*;

  logic [4*NUM_DIGITS-1:0] count_nxt;
  logic                    carry;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    count_nxt = count;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // NOTE: blocking '=' is required here: carry is a running value that
      // the next loop iteration reads within the same evaluation.
      if (carry) begin
        if (bcd_digit_t'(count[4*i +: 4]) == 4'd9) begin
          count_nxt[4*i +: 4] = 4'd0;
        end else begin
          count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Carry out of the top digit means every digit was 9.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= inc & carry;
      if (inc) count <= count_nxt;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_core.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_core
// N-digit BCD stopwatch: button synchronisers and edge detectors, control
// FSM, tick divider, lap hold register and multiplexed 7-segment drive.
//   CLK  : clock, all logic on the rising edge
//   RST  : synchronous active-high reset
//   bus  : stopwatch_if.slave (buttons in, seg/dp/dig_sel/status out)
// ---------------------------------------------------------------------------
module bcd_stopwatch_core #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 120000,
  parameter int MUX_DIV    = 1024,
  parameter int DP_POS     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  stopwatch_if.slave  bus
);
  import stopwatch_pkg::*;

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int MUX_W = $clog2(MUX_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam bit DP_EN = (DP_POS < NUM_DIGITS);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RUNNING = ST_RUNNING;
  localparam logic [1:0] S_STOPPED = ST_STOPPED;
  localparam logic [1:0] S_LAP     = ST_LAP;

  // Buttons: bit0 clear, bit1 startstop, bit2 lap. Two synchroniser stages,
  // a history stage, and a registered edge pulse (raw edge k -> state k+3).
  logic [2:0] btn_raw, sync1, sync2, sync3, edge_q;
  assign btn_raw = {bus.btn_lap, bus.btn_startstop, bus.btn_clear};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 & ~sync3;
    end
  end

  // Priority: clear over startstop over lap; losing edges are dropped.
  logic ev_clear, ev_ss, ev_lap;
  assign ev_clear = edge_q[0];
  assign ev_ss    = edge_q[1] & ~edge_q[0];
  assign ev_lap   = edge_q[2] & ~edge_q[1] & ~edge_q[0];

  logic [1:0] state, state_nxt;
  logic       lap_take;
  logic       counting;

  always_comb begin
    state_nxt = state;
    lap_take  = 1'b0;
    if (ev_clear) begin
      state_nxt = S_IDLE;
    end else if (ev_ss) begin
      case (state)
        S_RUNNING, S_LAP: state_nxt = S_STOPPED;
        default:          state_nxt = S_RUNNING;
      endcase
    end else if (ev_lap) begin
      if (state == S_RUNNING) begin
        state_nxt = S_LAP;
        lap_take  = 1'b1;
      end else if (state == S_LAP) begin
        state_nxt = S_RUNNING;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign counting       = (state == S_RUNNING) || (state == S_LAP);
  assign bus.running    = counting;
  assign bus.lap_active = (state == S_LAP);

  // Tick divider: runs while counting, holds in STOPPED, zero in IDLE.
  logic [DIV_W-1:0] div_cnt;
  logic             tick_end, inc;
  assign tick_end = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign inc      = counting & tick_end;

  always_ff @(posedge CLK) begin
    if (RST || ev_clear || state == S_IDLE) begin
      div_cnt <= '0;
    end else if (counting) begin
      div_cnt <= tick_end ? '0 : div_cnt + DIV_W'(1);
    end
  end

  logic [4*NUM_DIGITS-1:0] count, lap_q, disp;
  logic                    cnt_wrap;

  bcd_counter_n #(.NUM_DIGITS(NUM_DIGITS)) u_counter (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (ev_clear),
    .inc   (inc),
    .count (count),
    .wrap  (cnt_wrap)
  );
  assign bus.wrap = cnt_wrap;

  // Lap latch captures the pre-edge count on the RUNNING -> LAP edge.
  always_ff @(posedge CLK) begin
    if (RST || ev_clear) lap_q <= '0;
    else if (lap_take)   lap_q <= count;
  end

  assign disp = (state == S_LAP) ? lap_q : count;

  // Display mux: digit_idx is the digit driven at the next terminal count.
  logic [MUX_W-1:0] slot_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic             slot_end;
  assign slot_end = (slot_cnt == MUX_W'(MUX_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      bus.seg     <= 7'h7F;
      bus.dp      <= 1'b1;
      bus.dig_sel <= '1;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + MUX_W'(1);
      if (slot_end) begin
        bus.seg     <= ~bcd_to_seg(bcd_digit_t'(disp[4*digit_idx +: 4]));
        bus.dp      <= ~(DP_EN && digit_idx == IDX_W'(DP_POS));
        bus.dig_sel <= ~(NUM_DIGITS'(1) << digit_idx);
        digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                             : digit_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_core
// Drives buttons, keeps an integer-level reference of the stopwatch
// (decimal count, tick phase, lap value, display slot) and compares every
// DUT output against it each cycle, plus targeted scenario checks.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_core;

  localparam int ND   = 2;
  localparam int TD   = 4;
  localparam int MD   = 2;
  localparam int DPP  = 1;
  localparam int MAXC = 100;

  localparam int M_IDLE = 10;
  localparam int M_RUN  = 11;
  localparam int M_STOP = 12;
  localparam int M_LAP  = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_if #(.NUM_DIGITS(ND)) bus ();

  bcd_stopwatch_core #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .MUX_DIV(MD), .DP_POS(DPP)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int          m_state, m_count, m_lap, m_div, m_slot, m_next;
  logic        m_wrap, m_dp;
  logic [6:0]  m_seg;
  logic [ND-1:0] m_dig;
  logic [4:0]  h_c, h_s, h_l;

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int  src, d, dv, old_count;
    logic ec, es, el, cnt_on, inc;
    if (rst) begin
      m_state = M_IDLE; m_count = 0; m_lap = 0; m_div = 0;
      m_slot = 0; m_next = 0; m_wrap = 1'b0;
      m_seg = 7'h7F; m_dp = 1'b1; m_dig = '1;
      h_c = '0; h_s = '0; h_l = '0;
    end else begin
      ec = h_c[2] & ~h_c[3];
      es = h_s[2] & ~h_s[3];
      el = h_l[2] & ~h_l[3];
      src = (m_state == M_LAP) ? m_lap : m_count;
      if (m_slot == MD - 1) begin
        d       = m_next;
        dv      = (d == 0) ? src % 10 : (src / 10) % 10;
        m_seg   = ~pat(dv);
        m_dp    = (d != DPP);
        m_dig   = ~(ND'(1) << d);
        m_next  = (d + 1) % ND;
        m_slot  = 0;
      end else begin
        m_slot++;
      end
      cnt_on    = (m_state == M_RUN) || (m_state == M_LAP);
      inc       = cnt_on && (m_div == TD - 1);
      old_count = m_count;
      if (ec) begin
        m_state = M_IDLE; m_count = 0; m_lap = 0; m_div = 0; m_wrap = 1'b0;
      end else begin
        m_wrap = inc && (m_count == MAXC - 1);
        if (inc) m_count = (m_count + 1) % MAXC;
        if (m_state == M_IDLE) m_div = 0;
        else if (cnt_on)       m_div = (m_div + 1) % TD;
        if (es) begin
          m_state = cnt_on ? M_STOP : M_RUN;
        end else if (el) begin
          if (m_state == M_RUN) begin
            m_state = M_LAP;
            m_lap   = old_count;
          end else if (m_state == M_LAP) begin
            m_state = M_RUN;
          end
        end
      end
      h_c = {h_c[3:0], bus.btn_clear};
      h_s = {h_s[3:0], bus.btn_startstop};
      h_l = {h_l[3:0], bus.btn_lap};
    end
  end

  function automatic logic [12:0] obs();
    return {bus.seg, bus.dp, bus.dig_sel, bus.running, bus.lap_active, bus.wrap};
  endfunction

  function automatic logic [12:0] expv();
    return {m_seg, m_dp, m_dig, (m_state == M_RUN) || (m_state == M_LAP),
            m_state == M_LAP, m_wrap};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.btn_clear = 1'b0; bus.btn_startstop = 1'b0; bus.btn_lap = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs() !== {7'h7F, 1'b1, 2'b11, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values got %h expected %h", obs(), {7'h7F, 1'b1, 2'b11, 3'b000});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_startstop();
    bus.btn_startstop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.btn_startstop = 1'b0;
      n_tests++;
      if (bus.running !== (i == 3)) begin
        n_fail++;
        $display("FAIL run_latency edge+%0d got %b expected %b", i, bus.running, i == 3);
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL run_count cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_wrap();
    int  wrap_hi = 0;
    bit  seen_top = 0, done = 0;
    for (int i = 0; i < 700 && !done; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL wrap_run cyc %0d got %h expected %h", i, obs(), expv());
      end
      if (seen_top && bus.wrap === 1'b1) wrap_hi++;
      if (m_count == MAXC - 1) seen_top = 1;
      if (seen_top && m_count == 1) done = 1;
    end
    n_tests++;
    if (!done || wrap_hi != 1) begin
      n_fail++;
      $display("FAIL wrap_pulse got %0d high cycles (done=%0d) expected 1", wrap_hi, done);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) bus.btn_clear = 1'b1;
    if (which == 1) bus.btn_startstop = 1'b1;
    if (which == 2) bus.btn_lap = 1'b1;
    @(negedge clk);
    bus.btn_clear = 1'b0; bus.btn_startstop = 1'b0; bus.btn_lap = 1'b0;
  endtask

  task automatic test_lap();
    int guard = 0;
    pulse(0);
    repeat (6) @(negedge clk);
    pulse(1);
    while (!(m_count == 5 && m_state == M_RUN) && guard < 300) begin
      @(negedge clk); guard++;
    end
    pulse(2);
    guard = 0;
    while (m_count != 9 && guard < 300) begin
      @(negedge clk); guard++;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL lap_hold cyc %0d got %h expected %h", guard, obs(), expv());
      end
    end
    n_tests++;
    if (bus.lap_active !== 1'b1 || guard >= 300) begin
      n_fail++;
      $display("FAIL lap_active got %b expected 1 (guard %0d)", bus.lap_active, guard);
    end
    pulse(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL lap_release cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    while (m_count != 37 && guard < 400) begin
      @(negedge clk); guard++;
    end
    bus.btn_clear = 1'b1; bus.btn_startstop = 1'b1; bus.btn_lap = 1'b1;
    @(negedge clk);
    bus.btn_clear = 1'b0; bus.btn_startstop = 1'b0; bus.btn_lap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL simul cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
    n_tests++;
    if ({bus.running, bus.lap_active} !== 2'b00 || guard >= 400) begin
      n_fail++;
      $display("FAIL simul_state got %b%b expected 00 (guard %0d)",
               bus.running, bus.lap_active, guard);
    end
  endtask

  task automatic test_hold_and_resume();
    int rises = 0;
    logic prev;
    prev = bus.running;
    bus.btn_startstop = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.running === 1'b1 && prev === 1'b0) rises++;
      prev = bus.running;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL hold_level cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
    bus.btn_startstop = 1'b0;
    n_tests++;
    if (rises != 1 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_toggle got %0d rises running=%b expected 1 rise running=1",
               rises, bus.running);
    end
    repeat (5) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      pulse(1);
      for (int i = 0; i < 30 + 3 * p; i++) begin
        @(negedge clk);
        n_tests++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL stop_resume p%0d cyc %0d got %h expected %h", p, i, obs(), expv());
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      bus.btn_clear     = ($urandom_range(0, 59) == 0);
      bus.btn_startstop = ($urandom_range(0, 11) == 0);
      bus.btn_lap       = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h expected %h", i, obs(), expv());
      end
    end
    bus.btn_clear = 1'b0; bus.btn_startstop = 1'b0; bus.btn_lap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startstop();
    test_wrap();
    test_lap();
    test_simultaneous();
    test_hold_and_resume();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
